fpu_issue_ctrl: RTL and testbench

Sequencing controller for the non-pipelined floating-point unit that sits beside the EX stage. It accepts FPU ops decoded in ID and starts the FPU. It tracks the single in-flight destination register on a scoreboard and stalls ID on RAW/WAW or structural hazards. It also arbitrates the one regfile write port between the integer WB stage and the delayed FPU result, with a starvation guard.

---
 rtl/fpu_issue_ctrl_if.sv | 44 ++++
 rtl/fpu_issue_ctrl.sv | 134 +++++++++++++
 tb/tb_fpu_issue_ctrl.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fpu_issue_ctrl_if.sv
// Interface bundling the ID-stage request, FPU result, integer WB request and
// the controller's stall/start/regfile-write outputs for fpu_issue_ctrl.
interface fpu_issue_ctrl_if #(
  parameter int BUS_WIDTH    = 64,
  parameter int REGFILE_LEN  = 6,
  parameter int FPU_OP_WIDTH = 6,
  parameter int LAT_WIDTH    = 4
);
  logic                    id_valid;
  logic                    flush;
  logic                    id_alu_fpu;
  logic [FPU_OP_WIDTH-1:0] id_fpu_op;
  logic [LAT_WIDTH-1:0]    id_fpu_lat;
  logic                    id_reg_write;
  logic [REGFILE_LEN-1:0]  id_rs1;
  logic [REGFILE_LEN-1:0]  id_rs2;
  logic [REGFILE_LEN-1:0]  id_rd;
  logic [BUS_WIDTH-1:0]    fpu_result;
  logic                    wb_reg_write;
  logic [REGFILE_LEN-1:0]  wb_rd;
  logic [BUS_WIDTH-1:0]    wb_write_data;

  logic                    stall;
  logic                    fpu_start;
  logic [FPU_OP_WIDTH-1:0] fpu_op_out;
  logic                    fpu_busy;
  logic                    rf_write_enable;
  logic [REGFILE_LEN-1:0]  rf_write_addr;
  logic [BUS_WIDTH-1:0]    rf_write_data;

  modport master (
    output id_valid, flush, id_alu_fpu, id_fpu_op, id_fpu_lat, id_reg_write,
           id_rs1, id_rs2, id_rd, fpu_result, wb_reg_write, wb_rd, wb_write_data,
    input  stall, fpu_start, fpu_op_out, fpu_busy,
           rf_write_enable, rf_write_addr, rf_write_data
  );

  modport slave (
    input  id_valid, flush, id_alu_fpu, id_fpu_op, id_fpu_lat, id_reg_write,
           id_rs1, id_rs2, id_rd, fpu_result, wb_reg_write, wb_rd, wb_write_data,
    output stall, fpu_start, fpu_op_out, fpu_busy,
           rf_write_enable, rf_write_addr, rf_write_data
  );
endinterface

// File: rtl/fpu_issue_ctrl.sv
// Issue/sequencing controller for the non-pipelined FPU: starts ops from ID,
// tracks the single in-flight destination, stalls ID on hazards and shares
// the regfile write port with integer WB (WB first, with a starvation guard).
module fpu_issue_ctrl #(
  parameter int BUS_WIDTH    = 64,
  parameter int REGFILE_LEN  = 6,
  parameter int FPU_OP_WIDTH = 6,
  parameter int LAT_WIDTH    = 4,
  parameter int STARVE_LIMIT = 4
) (
  input logic            clk,
  input logic            rst_n,
  fpu_issue_ctrl_if.slave bus
);

  localparam int WAIT_WIDTH = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [LAT_WIDTH-1:0]    cnt_q, cnt_d;
  logic [REGFILE_LEN-1:0]  pend_rd_q, pend_rd_d;
  logic                    pend_valid_q, pend_valid_d;
  logic [BUS_WIDTH-1:0]    res_q, res_d;
  logic [WAIT_WIDTH-1:0]   wait_cnt_q, wait_cnt_d;

  logic                    grant;
  logic                    free;
  logic                    hazard;
  logic                    starve;
  logic                    stall;
  logic                    issue;
  logic [LAT_WIDTH-1:0]    lat_load;

  // Integer WB cannot stall, so the FPU only retires when WB leaves the port free.
  assign grant  = (state_q == DONE) & ~bus.wb_reg_write;
  assign free   = (state_q == IDLE) | grant;
  // Source compares are deliberately unqualified: a false stall is cheap, a missed one is not.
  assign hazard = pend_valid_q &
                  ((bus.id_reg_write & (bus.id_rd == pend_rd_q)) |
                   (bus.id_rs1 == pend_rd_q) |
                   (bus.id_rs2 == pend_rd_q));
  assign starve = (state_q == DONE) & (wait_cnt_q >= WAIT_WIDTH'(STARVE_LIMIT));
  assign stall  = bus.id_valid & ~bus.flush & (hazard | (bus.id_alu_fpu & ~free) | starve);
  assign issue  = bus.id_valid & bus.id_alu_fpu & ~bus.flush & ~stall;
  assign lat_load = (bus.id_fpu_lat == '0) ? LAT_WIDTH'(1) : bus.id_fpu_lat;

  assign bus.stall      = stall;
  assign bus.fpu_start  = issue;
  assign bus.fpu_op_out = issue ? bus.id_fpu_op : '0;
  assign bus.fpu_busy   = (state_q != IDLE);

  // State and scoreboard registers; reset drops any in-flight result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      pend_rd_q    <= '0;
      pend_valid_q <= 1'b0;
      res_q        <= '0;
      wait_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pend_rd_q    <= pend_rd_d;
      pend_valid_q <= pend_valid_d;
      res_q        <= res_d;
      wait_cnt_q   <= wait_cnt_d;
    end
  end

  // Next-state: count down the latency, hold the result until granted, then
  // retire; a new issue (only possible when free) loads the next op on top.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pend_rd_d    = pend_rd_q;
    pend_valid_d = pend_valid_q;
    res_d        = res_q;
    wait_cnt_d   = wait_cnt_q;

    case (state_q)
      IDLE: begin
      end
      BUSY: begin
        cnt_d = cnt_q - LAT_WIDTH'(1);
        if (cnt_q == LAT_WIDTH'(1)) begin
          res_d      = bus.fpu_result;
          wait_cnt_d = '0;
          state_d    = DONE;
        end
      end
      DONE: begin
        if (grant) begin
          pend_valid_d = 1'b0;
          state_d      = IDLE;
        end else if (wait_cnt_q < WAIT_WIDTH'(STARVE_LIMIT)) begin
          wait_cnt_d = wait_cnt_q + WAIT_WIDTH'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (issue) begin
      state_d      = BUSY;
      cnt_d        = lat_load;
      pend_rd_d    = bus.id_rd;
      pend_valid_d = bus.id_reg_write & (bus.id_rd != '0);
    end
  end

  // Regfile write port: integer WB wins, otherwise the granted FPU result.
  always_comb begin
    bus.rf_write_enable = 1'b0;
    bus.rf_write_addr   = '0;
    bus.rf_write_data   = '0;
    if (bus.wb_reg_write) begin
      bus.rf_write_enable = 1'b1;
      bus.rf_write_addr   = bus.wb_rd;
      bus.rf_write_data   = bus.wb_write_data;
    end else if (grant & pend_valid_q) begin
      bus.rf_write_enable = 1'b1;
      bus.rf_write_addr   = pend_rd_q;
      bus.rf_write_data   = res_q;
    end
  end

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Testbench for fpu_issue_ctrl: directed scenarios followed by random traffic,
// every cycle compared against a cycle-count based model of the in-flight op.
module tb_fpu_issue_ctrl;

  localparam int BW = 64;
  localparam int RL = 6;
  localparam int OW = 6;
  localparam int LW = 4;
  localparam int SL = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  fpu_issue_ctrl_if #(.BUS_WIDTH(BW), .REGFILE_LEN(RL), .FPU_OP_WIDTH(OW), .LAT_WIDTH(LW)) bus ();

  fpu_issue_ctrl #(
    .BUS_WIDTH(BW), .REGFILE_LEN(RL), .FPU_OP_WIDTH(OW), .LAT_WIDTH(LW), .STARVE_LIMIT(SL)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  int passCount  = 0;
  int checkCount = 0;

  int             cyc     = 0;
  bit             haveOp  = 1'b0;
  int             opIssue = 0;
  int             opLat   = 1;
  logic [RL-1:0]  opRd    = '0;
  bit             opWrite = 1'b0;
  logic [BW-1:0]  opRes   = '0;

  bit             expGrant, expStall, expIssue, expBusy, expEn;
  logic [RL-1:0]  expAddr;
  logic [BW-1:0]  expData;

  task automatic compare(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else $error("[TB] FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
  endtask

  task automatic applyStimulus(input int v, input int fl, input int fpu, input int lat,
                               input int rw, input int rs1, input int rs2, input int rd,
                               input logic [BW-1:0] res, input int wbw);
    bus.id_valid      = (v != 0);
    bus.flush         = (fl != 0);
    bus.id_alu_fpu    = (fpu != 0);
    bus.id_fpu_op     = OW'($urandom_range(0, 63));
    bus.id_fpu_lat    = LW'(lat);
    bus.id_reg_write  = (rw != 0);
    bus.id_rs1        = RL'(rs1);
    bus.id_rs2        = RL'(rs2);
    bus.id_rd         = RL'(rd);
    bus.fpu_result    = res;
    bus.wb_reg_write  = (wbw != 0);
    bus.wb_rd         = RL'($urandom_range(0, 63));
    bus.wb_write_data = {$urandom, $urandom};
  endtask

  task automatic idle(input logic [BW-1:0] res, input int wbw);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, res, wbw);
  endtask

  task automatic evalModel();
    int doneAt;
    bit donePh, freeNow, hazardNow, starveNow;
    if (!rst_n) haveOp = 1'b0;
    doneAt    = opIssue + opLat + 1;
    donePh    = haveOp && (cyc >= doneAt);
    expGrant  = donePh && !bus.wb_reg_write;
    freeNow   = !haveOp || expGrant;
    hazardNow = haveOp && opWrite &&
                ((bus.id_reg_write && (bus.id_rd == opRd)) ||
                 (bus.id_rs1 == opRd) || (bus.id_rs2 == opRd));
    starveNow = donePh && ((cyc - doneAt) >= SL);
    expStall  = bus.id_valid && !bus.flush &&
                (hazardNow || (bus.id_alu_fpu && !freeNow) || starveNow);
    expIssue  = bus.id_valid && bus.id_alu_fpu && !bus.flush && !expStall;
    expBusy   = haveOp;
    expEn     = 1'b0;
    expAddr   = '0;
    expData   = '0;
    if (bus.wb_reg_write) begin
      expEn   = 1'b1;
      expAddr = bus.wb_rd;
      expData = bus.wb_write_data;
    end else if (expGrant && opWrite) begin
      expEn   = 1'b1;
      expAddr = opRd;
      expData = opRes;
    end
  endtask

  task automatic checkOutput();
    @(negedge clk);
    evalModel();
    compare("stall", 64'(bus.stall), 64'(expStall));
    compare("fpu_start", 64'(bus.fpu_start), 64'(expIssue));
    compare("fpu_busy", 64'(bus.fpu_busy), 64'(expBusy));
    compare("rf_we", 64'(bus.rf_write_enable), 64'(expEn));
    if (expEn) begin
      compare("rf_addr", 64'(bus.rf_write_addr), 64'(expAddr));
      compare("rf_data", 64'(bus.rf_write_data), 64'(expData));
    end
    if (expIssue) compare("fpu_op", 64'(bus.fpu_op_out), 64'(bus.id_fpu_op));
  endtask

  task automatic endCycle();
    if (rst_n) begin
      if (haveOp && (cyc == opIssue + opLat)) opRes = bus.fpu_result;
      if (expGrant) haveOp = 1'b0;
      if (expIssue) begin
        haveOp  = 1'b1;
        opIssue = cyc;
        opLat   = (bus.id_fpu_lat == '0) ? 1 : int'(bus.id_fpu_lat);
        opRd    = bus.id_rd;
        opWrite = bus.id_reg_write && (bus.id_rd != '0);
      end
    end else begin
      haveOp = 1'b0;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  function automatic int pickReg();
    case ($urandom_range(0, 4))
      0:       return 0;
      1:       return 33;
      2:       return 34;
      3:       return 40;
      default: return 5;
    endcase
  endfunction

  // Directed scenarios, then random traffic against the reference model.
  initial begin
    bit wbHeavy;
    wbHeavy = 1'b0;

    rst_n = 1'b0;
    idle(64'h0, 0);
    checkOutput();
    compare("rst_busy", 64'(bus.fpu_busy), 64'd0);
    compare("rst_we", 64'(bus.rf_write_enable), 64'd0);
    endCycle();
    rst_n = 1'b1;
    idle(64'h0, 0); checkOutput(); endCycle();

    $display("[TB] basic issue and write-back");
    applyStimulus(1, 0, 1, 3, 1, 1, 2, 33, 64'h0, 0);
    checkOutput();
    compare("s1_start", 64'(bus.fpu_start), 64'd1);
    endCycle();
    for (int t = 1; t <= 3; t++) begin
      idle((t == 3) ? 64'h4000_0000_0000_0000 : 64'h0, 0);
      checkOutput(); endCycle();
    end
    idle(64'h0, 0); checkOutput();
    compare("s1_we", 64'(bus.rf_write_enable), 64'd1);
    compare("s1_addr", 64'(bus.rf_write_addr), 64'd33);
    compare("s1_data", 64'(bus.rf_write_data), 64'h4000_0000_0000_0000);
    endCycle();
    idle(64'h0, 0); checkOutput();
    compare("s1_busy", 64'(bus.fpu_busy), 64'd0);
    endCycle();

    $display("[TB] RAW dependent and unrelated op");
    applyStimulus(1, 0, 1, 3, 1, 1, 2, 33, 64'h0, 0); checkOutput(); endCycle();
    for (int t = 1; t <= 5; t++) begin
      applyStimulus(1, 0, 0, 0, 1, 33, 2, 10, {$urandom, $urandom}, 0);
      checkOutput();
      compare("s2_dep_stall", 64'(bus.stall), (t <= 4) ? 64'd1 : 64'd0);
      endCycle();
    end
    applyStimulus(1, 0, 1, 3, 1, 1, 2, 33, 64'h0, 0); checkOutput(); endCycle();
    for (int t = 1; t <= 5; t++) begin
      applyStimulus(1, 0, 0, 0, 1, 40, 40, 40, {$urandom, $urandom}, 0);
      checkOutput();
      compare("s2_unrel_stall", 64'(bus.stall), 64'd0);
      endCycle();
    end

    $display("[TB] back-to-back FPU ops");
    applyStimulus(1, 0, 1, 3, 1, 1, 2, 33, 64'h0, 0); checkOutput(); endCycle();
    for (int t = 1; t <= 4; t++) begin
      applyStimulus(1, 0, 1, 2, 1, 1, 2, 34, 64'h1234, 0);
      checkOutput();
      compare("s3_stall", 64'(bus.stall), (t <= 3) ? 64'd1 : 64'd0);
      if (t == 4) begin
        compare("s3_start", 64'(bus.fpu_start), 64'd1);
        compare("s3_we", 64'(bus.rf_write_enable), 64'd1);
        compare("s3_addr", 64'(bus.rf_write_addr), 64'd33);
      end
      endCycle();
    end
    for (int t = 0; t < 4; t++) begin idle({$urandom, $urandom}, 0); checkOutput(); endCycle(); end

    $display("[TB] WB priority and starvation");
    applyStimulus(1, 0, 1, 3, 1, 1, 2, 33, 64'h0, 0); checkOutput(); endCycle();
    for (int t = 1; t <= 10; t++) begin
      applyStimulus(1, 0, 0, 0, 1, 5, 5, 6, (t == 3) ? 64'h3ff0_0000_0000_0000 : 64'h0,
                    ((t >= 3) && (t <= 9)) ? 1 : 0);
      checkOutput();
      if ((t >= 4) && (t <= 7)) compare("s4_nostall", 64'(bus.stall), 64'd0);
      if ((t == 8) || (t == 9)) compare("s4_starve", 64'(bus.stall), 64'd1);
      if (t == 10) begin
        compare("s4_stall_grant", 64'(bus.stall), 64'd1);
        compare("s4_we", 64'(bus.rf_write_enable), 64'd1);
        compare("s4_addr", 64'(bus.rf_write_addr), 64'd33);
        compare("s4_data", 64'(bus.rf_write_data), 64'h3ff0_0000_0000_0000);
      end
      endCycle();
    end
    idle(64'h0, 0); checkOutput(); endCycle();

    $display("[TB] reset while busy and flush");
    applyStimulus(1, 0, 1, 4, 1, 1, 2, 33, 64'h0, 0); checkOutput(); endCycle();
    idle(64'h0, 0); checkOutput(); endCycle();
    rst_n = 1'b0;
    idle(64'h0, 0); checkOutput();
    compare("s5_rst_busy", 64'(bus.fpu_busy), 64'd0);
    endCycle();
    rst_n = 1'b1;
    for (int t = 3; t <= 8; t++) begin
      applyStimulus(1, 0, 0, 0, 1, 33, 2, 7, {$urandom, $urandom}, 0);
      checkOutput();
      compare("s5_nostall", 64'(bus.stall), 64'd0);
      compare("s5_nowrite", 64'(bus.rf_write_enable), 64'd0);
      endCycle();
    end
    applyStimulus(1, 0, 1, 2, 1, 1, 2, 34, 64'h0, 0); checkOutput(); endCycle();
    applyStimulus(1, 1, 1, 2, 1, 34, 34, 34, 64'h0, 0);
    checkOutput();
    compare("s5_flush_start", 64'(bus.fpu_start), 64'd0);
    compare("s5_flush_stall", 64'(bus.stall), 64'd0);
    endCycle();
    for (int t = 0; t < 3; t++) begin idle({$urandom, $urandom}, 0); checkOutput(); endCycle(); end

    $display("[TB] zero latency to x0");
    applyStimulus(1, 0, 1, 0, 1, 1, 2, 0, 64'h0, 0); checkOutput(); endCycle();
    for (int t = 1; t <= 3; t++) begin
      applyStimulus(1, 0, 0, 0, 1, 0, 0, 0, 64'h55, 0);
      checkOutput();
      compare("s6_nostall", 64'(bus.stall), 64'd0);
      if (t == 2) begin
        compare("s6_busy_done", 64'(bus.fpu_busy), 64'd1);
        compare("s6_nowrite", 64'(bus.rf_write_enable), 64'd0);
      end
      if (t == 3) compare("s6_idle", 64'(bus.fpu_busy), 64'd0);
      endCycle();
    end

    $display("[TB] random traffic");
    for (int n = 0; n < 800; n++) begin
      if ((n % 16) == 0) wbHeavy = ($urandom_range(0, 2) == 0);
      rst_n = ($urandom_range(0, 99) != 0);
      applyStimulus(($urandom_range(0, 9) < 7) ? 1 : 0,
                    ($urandom_range(0, 9) == 0) ? 1 : 0,
                    int'($urandom_range(0, 1)),
                    int'($urandom_range(0, 6)),
                    ($urandom_range(0, 3) != 0) ? 1 : 0,
                    pickReg(), pickReg(), pickReg(),
                    {$urandom, $urandom},
                    wbHeavy ? (($urandom_range(0, 9) < 9) ? 1 : 0)
                            : (($urandom_range(0, 9) < 3) ? 1 : 0));
      checkOutput();
      endCycle();
    end
    rst_n = 1'b1;

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
